// File: rtl/arbitro_divisor.sv
// Two-requester arbiter in front of one shared divider; define ROUND_ROBIN_EN for round-robin tie-break (default: port 0 wins).
// Grant to listo is 3 cycles plus divider busy time; divisor 0 bypasses the divider; no grant while div_termino=0.
`ifndef DdLen
`define DdLen 15
`endif
`ifndef DvLen
`define DvLen 7
`endif
`ifndef QLen
`define QLen 15
`endif

module arbitro_divisor (
  input  logic              clk,
  input  logic              reset_L,
  input  logic              solicitud0,
  input  logic              solicitud1,
  input  logic [`DdLen:0]   dividendo0,
  input  logic [`DdLen:0]   dividendo1,
  input  logic [`DvLen:0]   divisor0,
  input  logic [`DvLen:0]   divisor1,
  output logic              listo0,
  output logic              listo1,
  output logic [`QLen:0]    cociente0,
  output logic [`QLen:0]    cociente1,
  output logic              ocupado,
  output logic              div_inicie,
  output logic [`DdLen:0]   div_dividendo,
  output logic [`DvLen:0]   div_divisor,
  input  logic              div_termino,
  input  logic [`QLen:0]    div_cociente
);

  typedef enum logic [1:0] {IDLE, ARRANQUE, OCUPADO, ENTREGA} state_t;

  state_t            state;
  logic              gnt;
  logic              bypass;
  logic              grant_idx;
  logic              grant_fire;
  logic [`DdLen:0]   sel_dividendo;
  logic [`DvLen:0]   sel_divisor;
  logic [`QLen:0]    resultado;

  assign ocupado    = (state != IDLE);
  assign grant_fire = (state == IDLE) && div_termino && (solicitud0 || solicitud1);

`ifdef ROUND_ROBIN_EN
  logic ultimo;

  // On a tie, serve whoever was not granted last.
  always_comb begin
    grant_idx = solicitud1;
    if (solicitud0 && solicitud1) grant_idx = ~ultimo;
  end

  always_ff @(posedge clk) begin
    if (!reset_L) begin
      ultimo <= 1'b1;
    end else if (grant_fire) begin
      ultimo <= grant_idx;
    end
  end
`else
  always_comb begin
    grant_idx = ~solicitud0;
  end
`endif

  assign sel_dividendo = grant_idx ? dividendo1 : dividendo0;
  assign sel_divisor   = grant_idx ? divisor1   : divisor0;
  assign resultado     = bypass ? {(`QLen+1){1'b1}} : div_cociente;

  always_ff @(posedge clk) begin
    if (!reset_L) begin
      state         <= IDLE;
      div_inicie    <= 1'b0;
      listo0        <= 1'b0;
      listo1        <= 1'b0;
      cociente0     <= '0;
      cociente1     <= '0;
      div_dividendo <= '0;
      div_divisor   <= '0;
      gnt           <= 1'b0;
      bypass        <= 1'b0;
    end else begin
      listo0 <= 1'b0;
      listo1 <= 1'b0;
      case (state)
        IDLE: begin
          div_inicie <= 1'b0;
          if (grant_fire) begin
            div_dividendo <= sel_dividendo;
            div_divisor   <= sel_divisor;
            gnt           <= grant_idx;
            // Division by zero never reaches the divider; result is forced to all ones.
            if (sel_divisor == '0) begin
              bypass <= 1'b1;
              state  <= OCUPADO;
            end else begin
              bypass     <= 1'b0;
              div_inicie <= 1'b1;
              state      <= ARRANQUE;
            end
          end
        end
        ARRANQUE: begin
          if (!div_termino) state <= OCUPADO;
        end
        OCUPADO: begin
          if (bypass || div_termino) begin
            if (gnt) begin
              cociente1 <= resultado;
              listo1    <= 1'b1;
            end else begin
              cociente0 <= resultado;
              listo0    <= 1'b1;
            end
            div_inicie <= 1'b0;
            state      <= ENTREGA;
          end
        end
        ENTREGA: begin
          div_inicie <= 1'b0;
          state      <= IDLE;
        end
        default: begin
          div_inicie <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule
